// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory controller.
// Contents: FSM state enum, default width constants, index-width helper.
package data_mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Array index width; a single-word array still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dp_ram_core.sv
// 1W/2R synchronous data array with registered read ports.
// Ports: clk, rst (sync, clears read registers only); write port we/waddr/wdata;
// read ports a_/b_ with re (enable), raddr, zero (force result to 0) and rdata.
// Read results hold while re=0; a same-edge write to the read address is bypassed.
module dp_ram_core
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              a_re,
  input  logic [IDX_W-1:0]  a_raddr,
  input  logic              a_zero,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_re,
  input  logic [IDX_W-1:0]  b_raddr,
  input  logic              b_zero,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; no reset, the controller clears it word by word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered reads, write-first on address match.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_re) begin
        a_rdata <= a_zero ? '0 : ((we && (waddr == a_raddr)) ? wdata : mem[a_raddr]);
      end
      if (b_re) begin
        b_rdata <= b_zero ? '0 : ((we && (waddr == b_raddr)) ? wdata : mem[b_raddr]);
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: post-reset clear, request handshake, range check.
// Ports: CLK, RST (sync active-high); port A read/write (a_req, a_we, a_addr,
// a_wdata -> a_rdata, a_rvalid, a_err); port B read-only (b_req, b_addr ->
// b_rdata, b_rvalid); ready is low while the array is being cleared.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_err,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              ready
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_L = CNT_W'(DEPTH - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              a_in_c;
  logic              b_in_c;
  logic              a_acc_c;
  logic              b_acc_c;
  logic              a_rd_c;
  logic              we_c;
  logic [IDX_W-1:0]  waddr_c;
  logic [DATA_W-1:0] wdata_c;

  // Acceptance, range check and write-port steering (clear sweep vs port A).
  always_comb begin
    a_in_c  = {1'b0, a_addr} < DEPTH_L;
    b_in_c  = {1'b0, b_addr} < DEPTH_L;
    a_acc_c = (state == IDLE) && a_req;
    b_acc_c = (state == IDLE) && b_req;
    a_rd_c  = a_acc_c && !a_we;
    we_c    = 1'b0;
    waddr_c = a_addr[IDX_W-1:0];
    wdata_c = a_wdata;
    if (state == CLEAR) begin
      we_c    = !RST;
      waddr_c = cnt[IDX_W-1:0];
      wdata_c = '0;
    end else if (a_acc_c && a_we && a_in_c && !RST) begin
      we_c = 1'b1;
    end
  end

  // Controller FSM with clear counter and response strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLEAR;
      cnt      <= '0;
      ready    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
    end else begin
      a_rvalid <= a_rd_c;
      b_rvalid <= b_acc_c;
      a_err    <= a_acc_c && !a_in_c;
      case (state)
        CLEAR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_L) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  dp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (wdata_c),
    .a_re    (a_rd_c),
    .a_raddr (a_addr[IDX_W-1:0]),
    .a_zero  (!a_in_c),
    .a_rdata (a_rdata),
    .b_re    (b_acc_c),
    .b_raddr (b_addr[IDX_W-1:0]),
    .b_zero  (!b_in_c),
    .b_rdata (b_rdata)
  );

endmodule
